nes_pad_reader: RTL and testbench

Parametrised serial gamepad reader: polls NUM_PADS NES/SNES-style shift-register controllers over a shared latch/clock pair and a per-pad data line. Captures NUM_BITS buttons per pad each frame and publishes an active-high button bus with a one-cycle `valid` strobe. Optionally produces per-button press/release event pulses. Sits between the board pads and game logic, and supersedes the fixed 8-bit single-pad reader.

---
 rtl/nes_pad_reader_if.sv | 25 ++
 rtl/nes_pad_reader.sv | 165 ++++++++++++++++
 tb/tb_nes_pad_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_reader_if.sv
// rtl/nes_pad_reader_if.sv - Pad-side serial lines and game-side button bus of the NES/SNES pad reader
interface nes_pad_reader_if #(
  parameter int NUM_BITS = 8,
  parameter int NUM_PADS = 2
);
  logic [NUM_PADS-1:0]          pad_data;
  logic                         pad_latch;
  logic                         pad_clock;
  logic [NUM_PADS*NUM_BITS-1:0] buttons;
  logic                         valid;
  logic [NUM_PADS*NUM_BITS-1:0] pressed;
  logic [NUM_PADS*NUM_BITS-1:0] released;

  // The reader drives the pad strobes and the button bus.
  modport master (
    input  pad_data,
    output pad_latch, pad_clock, buttons, valid, pressed, released
  );

  // Pads drive the data lines; game logic consumes the button bus.
  modport slave (
    output pad_data,
    input  pad_latch, pad_clock, buttons, valid, pressed, released
  );
endinterface

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - Multi-pad NES/SNES shift-register reader; NESPAD_EDGE_EN adds press/release pulses
module nes_pad_reader #(
  parameter int CLK_DIV      = 256,
  parameter int NUM_BITS     = 8,
  parameter int NUM_PADS     = 2,
  parameter int FRAME_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              reset,
  nes_pad_reader_if.master bus
);
  localparam int W  = NUM_PADS * NUM_BITS;
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int FW = $clog2(FRAME_CYCLES);

  // Phase counter spans one full bit period (low half then high half);
  // the latch pulse reuses the same counter for its 2D cycles.
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH   = PW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_BITS - 1);
  localparam logic [FW-1:0] FR_LAST   = FW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LATCH,
    ST_SHIFT,
    ST_PUBLISH,
    ST_IDLE
  } state_t;

  state_t               state;
  logic [PW-1:0]        phase;
  logic [BW-1:0]        bit_idx;
  logic [FW-1:0]        frame_cnt;
  logic [NUM_PADS-1:0]  sync_a;
  logic [NUM_PADS-1:0]  sync_b;
  logic [W-1:0]         shreg;
  logic [W-1:0]         buttons_q;
  logic                 latch_q;
  logic                 clock_q;
  logic                 valid_q;
`ifdef NESPAD_EDGE_EN
  logic [W-1:0]         prev_q;
  logic [W-1:0]         pressed_q;
  logic [W-1:0]         released_q;
`endif

  // Two-flop synchroniser for the asynchronous pad data lines (idle = high).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= bus.pad_data;
      sync_b <= sync_a;
    end
  end

  // Free-running frame counter; wrapping to 0 marks the next latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FR_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Frame sequencer: latch, shift N bits from every pad, publish, idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LATCH;
      phase      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      buttons_q  <= '0;
      latch_q    <= 1'b0;
      clock_q    <= 1'b0;
      valid_q    <= 1'b0;
`ifdef NESPAD_EDGE_EN
      prev_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef NESPAD_EDGE_EN
      pressed_q  <= '0;
      released_q <= '0;
`endif
      case (state)
        ST_LATCH: begin
          latch_q <= 1'b1;
          clock_q <= 1'b0;
          if (phase == PH_LAST) begin
            phase   <= '0;
            bit_idx <= '0;
            state   <= ST_SHIFT;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_SHIFT: begin
          latch_q <= 1'b0;
          clock_q <= (phase >= PH_HIGH);
          // Sample on the last low-half cycle so the pad output has settled.
          if (phase == PH_SAMPLE) begin
            for (int p = 0; p < NUM_PADS; p++) begin
              for (int k = 0; k < NUM_BITS; k++) begin
                if (k == int'(bit_idx)) begin
                  shreg[p*NUM_BITS + k] <= ~sync_b[p];
                end
              end
            end
          end
          if (phase == PH_LAST) begin
            phase <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= ST_PUBLISH;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_PUBLISH: begin
          latch_q   <= 1'b0;
          clock_q   <= 1'b0;
          valid_q   <= 1'b1;
          buttons_q <= shreg;
`ifdef NESPAD_EDGE_EN
          pressed_q  <= shreg & ~prev_q;
          released_q <= ~shreg & prev_q;
          prev_q     <= shreg;
`endif
          state <= ST_IDLE;
        end
        default: begin
          latch_q <= 1'b0;
          clock_q <= 1'b0;
          if (frame_cnt == FR_LAST) begin
            phase <= '0;
            state <= ST_LATCH;
          end
        end
      endcase
    end
  end

  assign bus.pad_latch = latch_q;
  assign bus.pad_clock = clock_q;
  assign bus.buttons   = buttons_q;
  assign bus.valid     = valid_q;
`ifdef NESPAD_EDGE_EN
  assign bus.pressed   = pressed_q;
  assign bus.released  = released_q;
`else
  assign bus.pressed   = '0;
  assign bus.released  = '0;
`endif

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb/tb_nes_pad_reader.sv - Randomised self-checking bench for nes_pad_reader against a frame-position reference model
module tb_nes_pad_reader;
  localparam int D    = 4;
  localparam int N    = 8;
  localparam int P    = 2;
  localparam int FR   = 200;
  localparam int VCYC = (2 + 2 * N) * D;
`ifdef NESPAD_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nes_pad_reader_if #(.NUM_BITS(N), .NUM_PADS(P)) bus ();

  nes_pad_reader #(
    .CLK_DIV(D), .NUM_BITS(N), .NUM_PADS(P), .FRAME_CYCLES(FR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pad models: an 8-bit shift register per pad, reloaded while latch is high,
  // advanced by each rising pad_clock, driving the line active-low.
  logic [7:0] pad0, pad1;
  logic       unplug;
  int         sh_idx = 0;
  logic       clk_d = 1'b0;

  function automatic logic line_bit(input logic [7:0] v, input int i);
    logic [7:0] t;
    t = v >> i;
    return (i < 8) ? ~t[0] : 1'b1;
  endfunction

  always @(posedge clk) begin
    if (bus.pad_latch === 1'b1) sh_idx <= 0;
    else if (bus.pad_clock === 1'b1 && clk_d !== 1'b1) sh_idx <= sh_idx + 1;
    clk_d <= bus.pad_clock;
  end

  assign bus.pad_data = unplug ? 2'b11 : {line_bit(pad1, sh_idx), line_bit(pad0, sh_idx)};

  // Cycle bookkeeping: cyc-1 is the frame cycle of the edge just taken.
  int cyc = 0;
  int abs_cyc = 0;
  always @(posedge clk) begin
    abs_cyc <= abs_cyc + 1;
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  logic        mon_en = 1'b0;
  logic [15:0] prev_exp = '0;
  logic [15:0] hold_btn = '0;
  int          nvalid = 0;
  logic [15:0] snap_btn, snap_pr, snap_rl;
  int          snap_pos, snap_abs;

  // Reference model evaluated every cycle from the frame position.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == 0) begin
        check("rst_latch", 32'(bus.pad_latch), 32'd0);
        check("rst_clock", 32'(bus.pad_clock), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_buttons", 32'(bus.buttons), 32'd0);
        check("rst_pressed", 32'(bus.pressed), 32'd0);
        check("rst_released", 32'(bus.released), 32'd0);
        prev_exp = '0;
        hold_btn = '0;
      end else begin
        int pos;
        logic exp_clk;
        logic [15:0] exp_btn;
        pos = (cyc - 1) % FR;
        exp_clk = (pos >= 2 * D) && (pos < VCYC) && (((pos - 2 * D) % (2 * D)) >= D);
        check("latch", 32'(bus.pad_latch), 32'(pos < 2 * D));
        check("clock", 32'(bus.pad_clock), 32'(exp_clk));
        check("valid", 32'(bus.valid), 32'(pos == VCYC));
        if (pos == VCYC) begin
          exp_btn = unplug ? 16'h0 : {pad1, pad0};
          check("buttons", 32'(bus.buttons), 32'(exp_btn));
          check("pressed", 32'(bus.pressed), EDGE ? 32'(exp_btn & ~prev_exp) : 32'd0);
          check("released", 32'(bus.released), EDGE ? 32'(~exp_btn & prev_exp) : 32'd0);
          snap_btn = bus.buttons;
          snap_pr  = bus.pressed;
          snap_rl  = bus.released;
          snap_pos = cyc - 1;
          snap_abs = abs_cyc;
          prev_exp = exp_btn;
          hold_btn = exp_btn;
          nvalid++;
        end else begin
          check("hold_buttons", 32'(bus.buttons), 32'(hold_btn));
          check("idle_pressed", 32'(bus.pressed), 32'd0);
          check("idle_released", 32'(bus.released), 32'd0);
        end
      end
    end
  end

  task automatic wait_valid(input string tag);
    int start;
    int n;
    start = nvalid;
    n = 0;
    while (nvalid == start && n < 2 * FR) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(nvalid != start), 32'd1);
  endtask

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cyc > 0 && ((cyc - 1) % FR) == target) && n < 2 * FR);
    check("wait_pos", 32'(n < 2 * FR), 32'd1);
  endtask

  int t_prev;

  initial begin
    reset  = 1'b1;
    unplug = 1'b0;
    pad0   = 8'h5A;
    pad1   = 8'h81;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wait_valid("v_first");
    check("first_pos", 32'(snap_pos), 32'(VCYC));
    check("first_btn", 32'(snap_btn), 32'h815A);
    check("first_pr", 32'(snap_pr), EDGE ? 32'h815A : 32'h0);
    check("first_rl", 32'(snap_rl), 32'h0);

    pad0 = 8'h5B;
    wait_valid("v_5b");
    check("5b_btn", 32'(snap_btn), 32'h815B);
    check("5b_pr", 32'(snap_pr), EDGE ? 32'h0001 : 32'h0);
    check("5b_rl", 32'(snap_rl), 32'h0);

    pad0 = 8'h1B;
    wait_valid("v_1b");
    check("1b_btn", 32'(snap_btn), 32'h811B);
    check("1b_pr", 32'(snap_pr), 32'h0);
    check("1b_rl", 32'(snap_rl), EDGE ? 32'h0040 : 32'h0);

    wait_pos(39);
    reset = 1'b1;
    pad0 = 8'($urandom);
    pad1 = 8'($urandom);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_valid("v_after_rst");
    check("rst_valid_pos", 32'(snap_pos), 32'(VCYC));
    check("rst_btn", 32'(snap_btn), 32'({pad1, pad0}));
    check("rst_pr", 32'(snap_pr), EDGE ? 32'({pad1, pad0}) : 32'h0);

    unplug = 1'b1;
    wait_valid("v_unplug0");
    check("unplug_btn", 32'(snap_btn), 32'h0);
    t_prev = snap_abs;
    repeat (5) begin
      wait_valid("v_unplug");
      check("unplug_period", 32'(snap_abs - t_prev), 32'(FR));
      check("unplug_btn", 32'(snap_btn), 32'h0);
      check("unplug_pr", 32'(snap_pr), 32'h0);
      check("unplug_rl", 32'(snap_rl), 32'h0);
      t_prev = snap_abs;
    end

    unplug = 1'b0;
    repeat (6) begin
      pad0 = 8'($urandom);
      pad1 = 8'($urandom);
      wait_valid("v_rand");
      check("rand_btn", 32'(snap_btn), 32'({pad1, pad0}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
